adda_clk_rst_ctrl: RTL and testbench
====================================

ADDA_CLK_RST_CTRL -- requirements
Module: adda_clk_rst_ctrl

Interface
- REQ-001 SHALL have parameter RST_CYCLES, default 16: length of the PLL reset pulse, in sys_clk cycles.
- REQ-002 SHALL have parameter STABLE_CYCLES, default 1024: number of consecutive synchronized-lock-high cycles that qualify lock.
- REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536: maximum number of cycles in WAIT_LOCK before a retry.
- REQ-004 SHALL have parameter STAGGER_CYCLES, default 8: delay from ADC reset release to DAC reset release.
- REQ-005 SHALL have these ports, in this order: sys_clk in 1 (free-running 50 MHz board clock, same source as PLL clkin1); sys_rst_n in 1 (asynchronous active-low reset).
- REQ-006 SHALL have port pll_lock in 1: PLL LOCK output, asynchronous to sys_clk.
- REQ-007 SHALL have port soft_rst in 1: single-cycle request to restart the PLL sequence.
- REQ-008 SHALL have port clr_flags in 1: clears lock_lost and relock_cnt.
- REQ-009 SHALL have port pll_rst out 1: drives the PLL RST input, active-high.
- REQ-010 SHALL have ports adc_rst_n out 1 and dac_rst_n out 1: reset requests to the ADC and DAC clock domains.
- REQ-011 SHALL have port clk_ready out 1: both converter domains are released and lock is qualified.
- REQ-012 SHALL have port lock_lost out 1: sticky flag, set when lock drops after qualification or when WAIT_LOCK times out.
- REQ-013 SHALL have port relock_cnt out 8: saturating count of restarts caused by lock loss or timeout.
- REQ-014 SHALL have port state out 2: current FSM state encoding.

Function
- REQ-015 SHALL synchronize pll_lock with 2 flip-flops into lock_s, giving 2-cycle latency; all other inputs are synchronous to sys_clk.
- REQ-016 SHALL implement FSM states PLL_RST=0, WAIT_LOCK=1, RELEASE=2, RUN=3; all outputs are registered.
- REQ-017 PLL_RST: pll_rst=1, adc_rst_n=0, dac_rst_n=0, clk_ready=0; after RST_CYCLES cycles the FSM SHALL go to WAIT_LOCK.
- REQ-018 WAIT_LOCK: pll_rst=0; the stable counter SHALL count consecutive lock_s=1 cycles and SHALL clear on any lock_s=0 cycle.
- REQ-019 WAIT_LOCK: when the stable count reaches STABLE_CYCLES, the FSM SHALL go to RELEASE.
- REQ-020 WAIT_LOCK: the timeout counter SHALL count every cycle in the state; on reaching TIMEOUT_CYCLES the FSM SHALL go to PLL_RST, set lock_lost and increment relock_cnt.
- REQ-021 If the stable and timeout conditions occur in the same cycle, stable SHALL win.
- REQ-022 RELEASE: on entry adc_rst_n=1; STAGGER_CYCLES cycles later dac_rst_n=1 and clk_ready=1 in the same cycle, and the FSM SHALL go to RUN.
- REQ-023 In RELEASE or RUN, lock_s=0 SHALL cause a transition to PLL_RST on the next edge, with all domain resets reasserted and clk_ready=0 in that cycle.
- REQ-024 The lock drop in REQ-023 SHALL set lock_lost and increment relock_cnt.
- REQ-025 soft_rst=1 in any state SHALL cause a transition to PLL_RST with all counters cleared; it SHALL NOT set lock_lost or change relock_cnt.
- REQ-026 soft_rst SHALL have priority over every other transition.
- REQ-027 relock_cnt SHALL saturate at 255.
- REQ-028 clr_flags SHALL clear lock_lost and relock_cnt; if a set or increment event occurs in the same cycle, the set/increment SHALL win, leaving lock_lost=1 and relock_cnt=1.
- REQ-029 Counter widths SHALL be $clog2(max parameter + 1); counters SHALL clear on every state entry.

Reset
- REQ-030 When sys_rst_n=0 the block SHALL asynchronously force: state=PLL_RST, pll_rst=1, adc_rst_n=0, dac_rst_n=0, clk_ready=0, lock_lost=0, relock_cnt=0, all counters 0, synchronizer flops 0.
- REQ-031 Deassertion of sys_rst_n SHALL begin a full PLL_RST pulse of RST_CYCLES cycles.
- REQ-032 Reset asserted mid-sequence SHALL abort the sequence with no residual state.

Configuration
- REQ-033 With ADDA_RELOCK_CNT_EN defined, relock_cnt SHALL be implemented per REQ-013, REQ-020, REQ-024, REQ-027 and REQ-028.
- REQ-034 Without ADDA_RELOCK_CNT_EN, relock_cnt SHALL be tied to 0 with no counter logic; lock_lost behaviour is unchanged.

Structure
- REQ-035 Package adda_clk_pkg SHALL hold the state encodings and the default values of RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES and STAGGER_CYCLES.
- REQ-036 The lock synchronizer SHALL be sub-module adda_sync_2ff (async active-low reset, reset value 0), instantiated once.

Verification
- REQ-037 Release reset with pll_lock=1 held -> pll_rst=1 for 16 cycles; adc_rst_n rises 1024 cycles after lock_s first goes high; dac_rst_n and clk_ready rise 8 cycles after adc_rst_n; state=3.
- REQ-038 Glitch pll_lock low for 1 cycle at stable count 1000 -> stable counter restarts; adc_rst_n rises 1024 cycles after lock_s returns high.
- REQ-039 Hold pll_lock=0 -> after 65536 cycles in WAIT_LOCK, pll_rst pulses again, lock_lost=1, relock_cnt=1; after 3 timeouts relock_cnt=3.
- REQ-040 In RUN, drop pll_lock -> 3 cycles later adc_rst_n=0, dac_rst_n=0, clk_ready=0, pll_rst=1, relock_cnt increments; force 300 drops -> relock_cnt=255.
- REQ-041 soft_rst in RELEASE with clr_flags asserted in the same cycle as a lock loss -> soft_rst path taken, relock_cnt unchanged; lock-loss-plus-clear case yields lock_lost=1, relock_cnt=1.
- REQ-042 Assert sys_rst_n=0 mid-RELEASE -> all outputs at reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/adda_clk_pkg.sv
// Shared state encodings, default timing parameters and helpers for the
// ADC/DAC clock and reset controller.
package adda_clk_pkg;

  typedef enum logic [1:0] {
    StPllRst   = 2'd0,
    StWaitLock = 2'd1,
    StRelease  = 2'd2,
    StRun      = 2'd3
  } adda_state_e;

  localparam int unsigned DefRstCycles     = 16;
  localparam int unsigned DefStableCycles  = 1024;
  localparam int unsigned DefTimeoutCycles = 65536;
  localparam int unsigned DefStaggerCycles = 8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/adda_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module adda_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adda_clk_rst_ctrl.sv
// PLL reset / lock qualification and staggered ADC/DAC reset release.
// Optional saturating relock counter enabled by ADDA_RELOCK_CNT_EN.
module adda_clk_rst_ctrl
  import adda_clk_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = DefRstCycles,
  parameter int unsigned STABLE_CYCLES  = DefStableCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned STAGGER_CYCLES = DefStaggerCycles
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  input  logic       soft_rst,
  input  logic       clr_flags,
  output logic       pll_rst,
  output logic       adc_rst_n,
  output logic       dac_rst_n,
  output logic       clk_ready,
  output logic       lock_lost,
  output logic [7:0] relock_cnt,
  output logic [1:0] state
);

  localparam int unsigned MaxAB = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned MaxCD = (TIMEOUT_CYCLES > STAGGER_CYCLES) ?
                                  TIMEOUT_CYCLES : STAGGER_CYCLES;
  localparam int unsigned MaxCycles = (MaxAB > MaxCD) ? MaxAB : MaxCD;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t RstLast     = cnt_t'(RST_CYCLES - 1);
  localparam cnt_t StableLast  = cnt_t'(STABLE_CYCLES - 1);
  localparam cnt_t TimeoutLast = cnt_t'(TIMEOUT_CYCLES - 1);
  localparam cnt_t StaggerLast = cnt_t'(STAGGER_CYCLES - 1);

  adda_state_e state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  cnt_t        stable_q, stable_d;
  logic        lock_s;
  logic        lock_ev;
  logic        lock_lost_d;

  adda_sync_2ff u_lock_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // cnt_q is shared: reset pulse length, WAIT_LOCK timeout, RELEASE stagger.
  always_comb begin
    state_d = state_q;
    lock_ev = 1'b0;
    if (soft_rst) begin
      state_d = StPllRst;
    end else begin
      unique case (state_q)
        StPllRst: begin
          if (cnt_q == RstLast) state_d = StWaitLock;
        end
        StWaitLock: begin
          if (lock_s && (stable_q == StableLast)) begin
            state_d = StRelease;
          end else if (cnt_q == TimeoutLast) begin
            state_d = StPllRst;
            lock_ev = 1'b1;
          end
        end
        StRelease: begin
          if (!lock_s) begin
            state_d = StPllRst;
            lock_ev = 1'b1;
          end else if (cnt_q == StaggerLast) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!lock_s) begin
            state_d = StPllRst;
            lock_ev = 1'b1;
          end
        end
        default: state_d = StPllRst;
      endcase
    end
  end

  always_comb begin
    cnt_d    = '0;
    stable_d = '0;
    if (!soft_rst && (state_d == state_q)) begin
      cnt_d    = (state_q == StRun) ? cnt_q : cnt_q + cnt_t'(1);
      stable_d = ((state_q == StWaitLock) && lock_s) ? stable_q + cnt_t'(1) : '0;
    end
  end

  // A set event in the same cycle as a clear leaves the flag set.
  assign lock_lost_d = lock_ev ? 1'b1 : (clr_flags ? 1'b0 : lock_lost);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StPllRst;
      cnt_q     <= '0;
      stable_q  <= '0;
      pll_rst   <= 1'b1;
      adc_rst_n <= 1'b0;
      dac_rst_n <= 1'b0;
      clk_ready <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      pll_rst   <= (state_d == StPllRst);
      adc_rst_n <= (state_d == StRelease) || (state_d == StRun);
      dac_rst_n <= (state_d == StRun);
      clk_ready <= (state_d == StRun);
      lock_lost <= lock_lost_d;
    end
  end

  assign state = state_q;

`ifdef ADDA_RELOCK_CNT_EN
  logic [7:0] relock_q;
  logic [7:0] relock_base;

  assign relock_base = clr_flags ? 8'd0 : relock_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      relock_q <= 8'd0;
    end else begin
      relock_q <= lock_ev ? sat_inc8(relock_base) : relock_base;
    end
  end

  assign relock_cnt = relock_q;
`else
  assign relock_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_adda_clk_rst_ctrl.sv
// Directed self-checking bench for adda_clk_rst_ctrl with shortened timing
// parameters; relock expectations follow ADDA_RELOCK_CNT_EN.
module tb_adda_clk_rst_ctrl;

  localparam int unsigned RstC     = 4;
  localparam int unsigned StableC  = 20;
  localparam int unsigned TimeoutC = 60;
  localparam int unsigned StaggerC = 6;

`ifdef ADDA_RELOCK_CNT_EN
  localparam bit RelockEn = 1'b1;
`else
  localparam bit RelockEn = 1'b0;
`endif

  localparam int SigPll = 0;
  localparam int SigAdc = 1;
  localparam int SigDac = 2;
  localparam int SigRdy = 3;
  localparam int SigRel = 4;
  localparam int SigRun = 5;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       pll_lock;
  logic       soft_rst;
  logic       clr_flags;
  logic       pll_rst;
  logic       adc_rst_n;
  logic       dac_rst_n;
  logic       clk_ready;
  logic       lock_lost;
  logic [7:0] relock_cnt;
  logic [1:0] state;

  int n_cmp;
  int n_err;

  adda_clk_rst_ctrl #(
    .RST_CYCLES     (RstC),
    .STABLE_CYCLES  (StableC),
    .TIMEOUT_CYCLES (TimeoutC),
    .STAGGER_CYCLES (StaggerC)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pll_lock   (pll_lock),
    .soft_rst   (soft_rst),
    .clr_flags  (clr_flags),
    .pll_rst    (pll_rst),
    .adc_rst_n  (adc_rst_n),
    .dac_rst_n  (dac_rst_n),
    .clk_ready  (clk_ready),
    .lock_lost  (lock_lost),
    .relock_cnt (relock_cnt),
    .state      (state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      SigPll:  return pll_rst;
      SigAdc:  return adc_rst_n;
      SigDac:  return dac_rst_n;
      SigRdy:  return clk_ready;
      SigRel:  return state == 2'd2;
      SigRun:  return state == 2'd3;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exp_rc(input int v);
    return RelockEn ? v : 0;
  endfunction

  // Counts rising edges until the signal reaches val, then checks the count.
  task automatic wait_cnt(input string tag, input int which, input logic val,
                          input int limit, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (sig(which) !== val && n <= limit);
    check(tag, n, exp_n);
  endtask

  task automatic wait_for(input string tag, input int which, input logic val, input int limit);
    int n;
    n = 0;
    while (sig(which) !== val && n < limit) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, sig(which), val);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge sys_clk);
    clr_flags = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    sys_rst_n = 1'b0;
    pll_lock  = 1'b1;
    soft_rst  = 1'b0;
    clr_flags = 1'b0;
    repeat (3) @(negedge sys_clk);

    check("rst_state", state, 0);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_adc", adc_rst_n, 0);
    check("rst_dac", dac_rst_n, 0);
    check("rst_ready", clk_ready, 0);
    check("rst_lock_lost", lock_lost, 0);
    check("rst_relock", relock_cnt, 0);

    // Bring-up with lock held high.
    sys_rst_n = 1'b1;
    wait_cnt("up_pll_pulse", SigPll, 1'b0, 20, RstC);
    wait_cnt("up_adc_delay", SigAdc, 1'b1, 40, StableC);
    check("up_state_rel", state, 2);
    check("up_dac_low", dac_rst_n, 0);
    wait_cnt("up_dac_delay", SigDac, 1'b1, 20, StaggerC);
    check("up_ready", clk_ready, 1);
    check("up_state_run", state, 3);
    check("up_lock_lost", lock_lost, 0);

    // Soft reset from RUN, then a one-cycle lock glitch during qualification.
    soft_rst = 1'b1;
    @(negedge sys_clk);
    soft_rst = 1'b0;
    check("soft_state", state, 0);
    check("soft_pll_rst", pll_rst, 1);
    check("soft_adc", adc_rst_n, 0);
    check("soft_ready", clk_ready, 0);
    check("soft_lock_lost", lock_lost, 0);
    wait_cnt("soft_pll_pulse", SigPll, 1'b0, 20, RstC);
    repeat (15) @(negedge sys_clk);
    pll_lock = 1'b0;
    @(negedge sys_clk);
    pll_lock = 1'b1;
    wait_cnt("glitch_adc_delay", SigAdc, 1'b1, 40, StableC + 2);
    wait_cnt("glitch_dac_delay", SigDac, 1'b1, 20, StaggerC);

    // Lock loss in RUN.
    pll_lock = 1'b0;
    wait_cnt("drop_latency", SigAdc, 1'b0, 10, 3);
    check("drop_dac", dac_rst_n, 0);
    check("drop_ready", clk_ready, 0);
    check("drop_pll_rst", pll_rst, 1);
    check("drop_state", state, 0);
    check("drop_lock_lost", lock_lost, 1);
    check("drop_relock", relock_cnt, exp_rc(1));

    // Clear, then three WAIT_LOCK timeouts with lock held low.
    pulse_clr();
    check("clr_lock_lost", lock_lost, 0);
    check("clr_relock", relock_cnt, 0);
    wait_cnt("to_pll_fall0", SigPll, 1'b0, 20, RstC - 1);
    for (int i = 0; i < 3; i++) begin
      wait_cnt("to_timeout", SigPll, 1'b1, 80, TimeoutC);
      check("to_lock_lost", lock_lost, 1);
      check("to_relock", relock_cnt, exp_rc(i + 1));
      if (i < 2) wait_cnt("to_pll_fall", SigPll, 1'b0, 20, RstC);
    end

    // Repeated lock loss drives the counter into saturation.
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1;
      wait_for("sat_run", SigRun, 1'b1, 100);
      pll_lock = 1'b0;
      wait_for("sat_drop", SigPll, 1'b1, 10);
      if (i == 199) check("sat_mid", relock_cnt, exp_rc(203));
    end
    check("sat_final", relock_cnt, exp_rc(255));

    // Lock loss coinciding with clr_flags: the set/increment wins.
    pll_lock = 1'b1;
    wait_for("clr_ev_run", SigRun, 1'b1, 100);
    pll_lock = 1'b0;
    repeat (2) @(negedge sys_clk);
    clr_flags = 1'b1;
    @(negedge sys_clk);
    clr_flags = 1'b0;
    check("clr_ev_state", state, 0);
    check("clr_ev_lock_lost", lock_lost, 1);
    check("clr_ev_relock", relock_cnt, exp_rc(1));

    // soft_rst in RELEASE on the same edge as a lock loss: no flag update.
    pulse_clr();
    check("clr2_lock_lost", lock_lost, 0);
    pll_lock = 1'b1;
    wait_for("sr_rel", SigRel, 1'b1, 100);
    pll_lock = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("sr_still_rel", state, 2);
    soft_rst = 1'b1;
    @(negedge sys_clk);
    soft_rst = 1'b0;
    check("sr_state", state, 0);
    check("sr_pll_rst", pll_rst, 1);
    check("sr_lock_lost", lock_lost, 0);
    check("sr_relock", relock_cnt, 0);

    // Asynchronous reset mid-RELEASE after a lock loss has been recorded.
    pll_lock = 1'b1;
    wait_for("ar_run", SigRun, 1'b1, 100);
    pll_lock = 1'b0;
    wait_for("ar_drop", SigPll, 1'b1, 10);
    pll_lock = 1'b1;
    wait_for("ar_rel", SigRel, 1'b1, 100);
    #2 sys_rst_n = 1'b0;
    #1;
    check("ar_state", state, 0);
    check("ar_pll_rst", pll_rst, 1);
    check("ar_adc", adc_rst_n, 0);
    check("ar_dac", dac_rst_n, 0);
    check("ar_ready", clk_ready, 0);
    check("ar_lock_lost", lock_lost, 0);
    check("ar_relock", relock_cnt, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_cnt("ar_pll_pulse", SigPll, 1'b0, 20, RstC);
    wait_cnt("ar_adc_delay", SigAdc, 1'b1, 40, StableC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
